// File: rtl/mem_access_unit.sv
// Memory-access / write-back stage: one instruction per handshake, drives the data-memory req/ack port and the register write port.
// Optional feature: define MAU_SUBWORD_EN for byte/halfword accesses; otherwise every access is a full aligned word.
module mem_access_unit #(
    parameter int AW = 32
) (
    input  logic          CLK,
    input  logic          RST_X,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_load,
    input  logic          in_store,
    input  logic          in_we_reg,
    input  logic [31:0]   in_addr,
    input  logic [31:0]   in_wdata,
    input  logic [2:0]    in_funct3,
    input  logic [4:0]    in_rd,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [AW-1:0] dmem_addr,
    output logic [31:0]   dmem_wdata,
    output logic [3:0]    dmem_wstrb,
    input  logic [31:0]   dmem_rdata,
    input  logic          dmem_ack,
    output logic          wb_we,
    output logic [4:0]    wb_rd,
    output logic [31:0]   wb_data,
    output logic          misalign,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_in_ready;
    logic        r_dmem_req;
    logic        r_we;
    logic [AW-3:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic [4:0]  r_rd;
    logic        r_wb_we;
    logic [31:0] r_wb_data;
    logic        r_misalign;

    logic        w_misaligned;
    logic [31:0] w_lane_wdata;
    logic [3:0]  w_lane_wstrb;
    logic [31:0] w_load_data;

`ifdef MAU_SUBWORD_EN
    logic [2:0]  r_funct3;
    logic [1:0]  r_off;
    logic [31:0] w_shifted;

    always_comb begin
        w_misaligned = 1'b0;
        w_lane_wdata = in_wdata;
        w_lane_wstrb = 4'b1111;
        case (in_funct3[1:0])
            2'b00: begin
                w_lane_wdata = {4{in_wdata[7:0]}};
                w_lane_wstrb = 4'b0001 << in_addr[1:0];
            end
            2'b01: begin
                w_misaligned = in_addr[0];
                w_lane_wdata = {2{in_wdata[15:0]}};
                w_lane_wstrb = 4'b0011 << in_addr[1:0];
            end
            default: w_misaligned = |in_addr[1:0];
        endcase
    end

    // Bring the addressed lane down to bit 0 before extension.
    assign w_shifted = dmem_rdata >> {r_off, 3'b000};

    always_comb begin
        w_load_data = w_shifted;
        case (r_funct3)
            3'b000:  w_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'b100:  w_load_data = {24'd0, w_shifted[7:0]};
            3'b001:  w_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b101:  w_load_data = {16'd0, w_shifted[15:0]};
            default: w_load_data = w_shifted;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            r_funct3 <= 3'd0;
            r_off    <= 2'd0;
        end else if (r_state == S_IDLE && in_valid) begin
            r_funct3 <= in_funct3;
            r_off    <= in_addr[1:0];
        end
    end
`else
    logic w_unused_funct3;

    assign w_unused_funct3 = ^in_funct3;
    assign w_misaligned    = |in_addr[1:0];
    assign w_lane_wdata    = in_wdata;
    assign w_lane_wstrb    = 4'b1111;
    assign w_load_data     = dmem_rdata;
`endif

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b1;
            r_dmem_req <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= 32'd0;
            r_wstrb    <= 4'd0;
            r_rd       <= 5'd0;
            r_wb_we    <= 1'b0;
            r_wb_data  <= 32'd0;
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= 1'b0;
            r_wb_we    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_rd   <= in_rd;
                        r_addr <= in_addr[AW-1:2];
                        if (in_load || in_store) begin
                            if (w_misaligned) begin
                                r_misalign <= 1'b1;
                            end else begin
                                // Load wins when both flags are set.
                                r_state    <= S_REQ;
                                r_in_ready <= 1'b0;
                                r_dmem_req <= 1'b1;
                                r_we       <= ~in_load;
                                r_wdata    <= w_lane_wdata;
                                r_wstrb    <= in_load ? 4'b0000 : w_lane_wstrb;
                            end
                        end else if (in_we_reg) begin
                            r_state    <= S_WB;
                            r_in_ready <= 1'b0;
                            r_wb_data  <= in_addr;
                            r_wb_we    <= (in_rd != 5'd0);
                        end
                    end
                end
                S_REQ: begin
                    if (dmem_ack) begin
                        r_dmem_req <= 1'b0;
                        if (r_we) begin
                            r_state    <= S_IDLE;
                            r_in_ready <= 1'b1;
                        end else begin
                            r_state   <= S_WB;
                            r_wb_data <= w_load_data;
                            r_wb_we   <= (r_rd != 5'd0);
                        end
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign dmem_req   = r_dmem_req;
    assign dmem_we    = r_we;
    assign dmem_addr  = {r_addr, 2'b00};
    assign dmem_wdata = r_wdata;
    assign dmem_wstrb = r_wstrb;
    assign wb_we      = r_wb_we;
    assign wb_rd      = r_rd;
    assign wb_data    = r_wb_data;
    assign misalign   = r_misalign;
    assign dbg_state  = r_state;

endmodule
